// File: rtl/systolic_seq_pkg.sv
// Shared definitions for the systolic array sequencer: FSM states, array geometry, lane helper.
// The optional ReLU on captured results is selected with SYSTOLIC_SEQ_RELU_EN.
package systolic_seq_pkg;

  localparam int N        = 6;
  localparam int WIDTH    = 16;
  localparam int FRAC_BIT = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [WIDTH-1:0] lane_of(input logic [N*WIDTH-1:0] vec, input int idx);
    return vec[idx*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/systolic_seq_tokpipe.sv
// Valid-token shadow of the systolic array pipeline: a 1 marks a real vector, 0 a bubble.
// Shifts only when the array is enabled so tokens stay aligned with the frozen array data.
module systolic_seq_tokpipe #(
  parameter int DEPTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic inject,
  output logic tail,
  output logic empty
);

  logic [DEPTH-1:0] tok;
  logic [DEPTH-1:0] tok_next;

  if (DEPTH == 1) begin : g_single
    assign tok_next = inject;
  end else begin : g_multi
    assign tok_next = {tok[DEPTH-2:0], inject};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok <= '0;
    end else if (shift_en) begin
      tok <= tok_next;
    end
  end

  assign tail  = tok[DEPTH-1];
  assign empty = ~|tok;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 6x6 systolic MAC array: clear, feed vectors, drain, pulse done.
// Define SYSTOLIC_SEQ_RELU_EN to clamp negative result lanes to zero on capture.
module systolic_seq_ctrl
  import systolic_seq_pkg::*;
#(
  parameter int PIPE_LAT = 12,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N*WIDTH-1:0]   s_data,
  output logic                 arr_en,
  output logic                 arr_clr,
  output logic [N*WIDTH-1:0]   arr_a,
  input  logic [N*WIDTH-1:0]   arr_y,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N*WIDTH-1:0]   m_data,
  output logic                 busy,
  output logic                 done
);

  state_t             state;
  logic [CNT_W-1:0]   num_vec_q;
  logic [CNT_W-1:0]   vec_cnt;
  logic               stall;
  logic               accept;
  logic               capture;
  logic               tok_tail;
  logic               tok_empty;
  logic [N*WIDTH-1:0] y_cap;

  // A pending result that cannot leave freezes the whole array, tokens included.
  assign stall   = m_valid & ~m_ready;
  assign arr_en  = ((state == FEED) | (state == DRAIN)) & ~stall;
  assign accept  = (state == FEED) & arr_en & s_valid;
  assign s_ready = accept;
  assign arr_a   = accept ? s_data : '0;
  assign arr_clr = (state == CLEAR);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign capture = tok_tail & ~stall;

  systolic_seq_tokpipe #(
    .DEPTH(PIPE_LAT)
  ) u_tokpipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_en(arr_en),
    .inject  (accept),
    .tail    (tok_tail),
    .empty   (tok_empty)
  );

`ifdef SYSTOLIC_SEQ_RELU_EN
  for (genvar g = 0; g < N; g++) begin : g_relu
    logic [WIDTH-1:0] lane;
    assign lane = lane_of(arr_y, g);
    assign y_cap[g*WIDTH +: WIDTH] = lane[WIDTH-1] ? '0 : lane;
  end
`else
  assign y_cap = arr_y;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_vec_q <= '0;
      vec_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_vec_q <= num_vec;
            vec_cnt   <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: state <= (num_vec_q == '0) ? DRAIN : FEED;
        FEED: begin
          if (accept) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
            if (vec_cnt == num_vec_q - CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tok_empty && !m_valid) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh capture wins over the handshake, so back-to-back results never drop m_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_data  <= y_cap;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: array model plus expected-result queue in input order.
// Build with SYSTOLIC_SEQ_RELU_EN to expect negative lanes clamped to zero.
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;
  import systolic_seq_pkg::*;

  localparam int PIPE_LAT = 12;
  localparam int CNT_W    = 8;
  localparam int VW       = N*WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [VW-1:0]    s_data = '0;
  logic             arr_en;
  logic             arr_clr;
  logic [VW-1:0]    arr_a;
  logic [VW-1:0]    arr_y;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [VW-1:0]    m_data;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [VW-1:0] exp_q[$];
  int clr_cnt, done_cnt, res_cnt, mv_cnt, clr_cyc, done_cyc, acc_cyc;
  bit lat_armed, acc_seen, mv_seen, prev_stall;
  logic [VW-1:0] prev_mdata;
  logic [VW-1:0] apipe [PIPE_LAT];

  systolic_seq_ctrl #(
    .PIPE_LAT(PIPE_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .num_vec(num_vec),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .arr_en (arr_en),
    .arr_clr(arr_clr),
    .arr_a  (arr_a),
    .arr_y  (arr_y),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Array model: y is a delayed PIPE_LAT enabled cycles, wiped by clr.
  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < PIPE_LAT; i++) apipe[i] <= '0;
    end else if (arr_en) begin
      apipe[0] <= arr_a;
      for (int i = 1; i < PIPE_LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign arr_y = apipe[PIPE_LAT-1];

  function automatic logic [VW-1:0] ref_result(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef SYSTOLIC_SEQ_RELU_EN
    for (int i = 0; i < N; i++)
      if (v[i*WIDTH + WIDTH - 1]) r[i*WIDTH +: WIDTH] = '0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] actual,
                             input logic [VW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_s_ready"}, VW'(s_ready), '0);
    checkOutput({tag, "_arr_en"},  VW'(arr_en),  '0);
    checkOutput({tag, "_arr_clr"}, VW'(arr_clr), '0);
    checkOutput({tag, "_arr_a"},   arr_a,        '0);
    checkOutput({tag, "_m_valid"}, VW'(m_valid), '0);
    checkOutput({tag, "_m_data"},  m_data,       '0);
    checkOutput({tag, "_busy"},    VW'(busy),    '0);
    checkOutput({tag, "_done"},    VW'(done),    '0);
  endtask

  // Monitor: pops the scoreboard on every result handshake and watches stall behaviour.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arr_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (m_valid) mv_cnt++;
      if (s_ready) checkOutput("arr_a_pass", arr_a, s_data);
      else         checkOutput("arr_a_zero", arr_a, '0);
      if (m_valid && !m_ready) begin
        checkOutput("stall_arr_en",  VW'(arr_en),  '0);
        checkOutput("stall_s_ready", VW'(s_ready), '0);
        if (prev_stall) checkOutput("stall_m_data", m_data, prev_mdata);
        prev_stall = 1'b1;
        prev_mdata = m_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got %h expected none", m_data);
        end else begin
          checkOutput("result_data", m_data, exp_q.pop_front());
          res_cnt++;
        end
      end
      if (lat_armed) begin
        if (!acc_seen && s_valid && s_ready) begin
          acc_seen = 1'b1;
          acc_cyc  = cyc;
        end
        if (acc_seen && !mv_seen && m_valid) begin
          mv_seen = 1'b1;
          checkOutput("first_latency", VW'(cyc - acc_cyc), VW'(PIPE_LAT + 1));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clearCounters();
    clr_cnt = 0; done_cnt = 0; res_cnt = 0; mv_cnt = 0;
    acc_seen = 1'b0; mv_seen = 1'b0; prev_stall = 1'b0;
  endtask

  // One job: optional 2-cycle input gap, optional 20-cycle output stall, optional start while busy.
  task automatic applyStimulus(input int nv, input int gap_at, input bit do_stall,
                               input bit busy_start, input bit fixed, input bit lat);
    logic [VW-1:0] vecs[$];
    logic [15:0]   lane0 [5];
    bit            acc;
    bit            seen_done;
    int            budget;
    lane0 = '{16'hFB33, 16'h0133, 16'h0266, 16'h0533, 16'h0533};
    for (int i = 0; i < nv; i++) begin
      logic [VW-1:0] v;
      v = {$urandom, $urandom, $urandom};
      if (fixed && i < 5) v[WIDTH-1:0] = lane0[i];
      vecs.push_back(v);
      exp_q.push_back(ref_result(v));
    end
    clearCounters();
    lat_armed = lat;
    @(posedge clk); #1;
    start = 1'b1;
    num_vec = CNT_W'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    num_vec = CNT_W'($urandom);
    checkOutput("busy_after_start", VW'(busy), VW'(1));
    fork
      begin
        for (int i = 0; i < nv; i++) begin
          if (i == gap_at) begin
            s_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
          end
          s_valid = 1'b1;
          s_data  = vecs[i];
          if (busy_start && i == 1) begin
            start   = 1'b1;
            num_vec = CNT_W'(nv + 3);
          end
          budget = 0;
          do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
          end while (!acc && budget < 200);
          if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: got no s_ready expected beat %0d accepted", i);
            break;
          end
        end
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom, $urandom};
      end
      begin
        if (do_stall) begin
          for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (m_valid) break;
          end
          @(posedge clk); #1;
          m_ready = 1'b0;
          repeat (20) @(posedge clk);
          #1;
          m_ready = 1'b1;
        end
      end
    join
    seen_done = 1'b0;
    for (int k = 0; k < 600 && !seen_done; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checkOutput("done_seen", VW'(seen_done), VW'(1));
    repeat (3) @(negedge clk);
    checkOutput("result_count", VW'(res_cnt), VW'(nv));
    checkOutput("queue_empty",  VW'(exp_q.size()), '0);
    checkOutput("clr_count",    VW'(clr_cnt), VW'(1));
    checkOutput("done_count",   VW'(done_cnt), VW'(1));
    checkOutput("idle_busy",    VW'(busy), '0);
    if (lat) checkOutput("latency_measured", VW'(mv_seen), VW'(1));
    if (nv == 0) begin
      checkOutput("nv0_no_valid",    VW'(mv_cnt), '0);
      checkOutput("nv0_clr_to_done", VW'(done_cyc - clr_cyc), VW'(2));
    end
    lat_armed = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkQuiet("post_reset");

    applyStimulus(5, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(5,  2, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(5, -1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4, -1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of FEED abandons the job silently.
    clearCounters();
    @(posedge clk); #1;
    start = 1'b1;
    num_vec = CNT_W'(8);
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = {$urandom, $urandom, $urandom};
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkQuiet("mid_reset");
    s_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    checkOutput("mid_reset_no_done", VW'(done_cnt), '0);
    applyStimulus(5, -1, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int j = 0; j < 6; j++) begin
      int nv;
      nv = $urandom_range(1, 24);
      applyStimulus(nv, ($urandom_range(0, 1) == 1) ? $urandom_range(0, nv - 1) : -1,
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
